// File: rtl/io_clock_generator.sv
// io_clock_generator: programmable serial IO clock with burst length, graceful stop,
// abort, and quarter-period phase strobes for serial shift engines.
module io_clock_generator #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   async_rst_n,
    input  logic                   clk_en,
    input  logic [DIV_WIDTH-1:0]   clock_divisor,
    input  logic                   idle_polarity,
    input  logic [COUNT_WIDTH-1:0] cycle_count,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   abort,
    output logic                   sclk,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] period_count,
    output logic                   first_center,
    output logic                   first_edge,
    output logic                   second_center,
    output logic                   second_edge
);

    localparam int unsigned MIN_DIV = 4;
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]             rst_sync_q;
    logic                   rst_n;

    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [COUNT_WIDTH-1:0] ccount_q, ccount_d;
    logic                   pol_q, pol_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   sclk_q, sclk_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] pcount_q, pcount_d;
    logic                   fc_q, fc_d;
    logic                   fe_q, fe_d;
    logic                   sc_q, sc_d;
    logic                   se_q, se_d;

    logic [DIV_WIDTH-1:0]   quarter_c;
    logic [DIV_WIDTH-1:0]   half_c;
    logic [DIV_WIDTH-1:0]   lim_fc_c;
    logic [DIV_WIDTH-1:0]   lim_fe_c;
    logic [DIV_WIDTH-1:0]   lim_sc_c;
    logic [DIV_WIDTH-1:0]   lim_se_c;
    logic [DIV_WIDTH-1:0]   div_sel_c;
    logic [COUNT_WIDTH-1:0] pcount_inc_c;
    logic                   start_ok_c;
    logic                   hit_se_c;
    logic                   last_c;

    // Reset synchronizer: assertion is immediate, release is aligned to clk
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Phase limits derived from the latched divisor (divisor is never below 4)
    assign quarter_c    = div_q >> 2;
    assign half_c       = div_q >> 1;
    assign lim_fc_c     = quarter_c - DIV_WIDTH'(1);
    assign lim_fe_c     = half_c - DIV_WIDTH'(1);
    assign lim_sc_c     = half_c + quarter_c - DIV_WIDTH'(1);
    assign lim_se_c     = div_q - DIV_WIDTH'(1);
    assign div_sel_c    = (clock_divisor < MIN_DIV_W) ? MIN_DIV_W : clock_divisor;
    assign pcount_inc_c = pcount_q + COUNT_WIDTH'(1);
    assign start_ok_c   = start && !abort;
    assign hit_se_c     = (cnt_q == lim_se_c);
    assign last_c       = ((ccount_q != '0) && (pcount_inc_c == ccount_q)) || stop_pend_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort wins over everything, bursts end on a period boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || (hit_se_c && last_c)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: phase counter, sclk, strobes, period bookkeeping
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        ccount_d    = ccount_q;
        pol_d       = pol_q;
        stop_pend_d = stop_pend_q;
        sclk_d      = sclk_q;
        done_d      = 1'b0;
        pcount_d    = pcount_q;
        fc_d        = 1'b0;
        fe_d        = 1'b0;
        sc_d        = 1'b0;
        se_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = idle_polarity;
                if (start_ok_c) begin
                    cnt_d       = '0;
                    pcount_d    = '0;
                    stop_pend_d = stop;
                    div_d       = div_sel_c;
                    ccount_d    = cycle_count;
                    pol_d       = idle_polarity;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    sclk_d      = idle_polarity;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                end else begin
                    fc_d  = (cnt_q == lim_fc_c);
                    fe_d  = (cnt_q == lim_fe_c);
                    sc_d  = (cnt_q == lim_sc_c);
                    se_d  = hit_se_c;
                    cnt_d = hit_se_c ? '0 : cnt_q + DIV_WIDTH'(1);
                    if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                    if (cnt_q == lim_fe_c) begin
                        sclk_d = ~pol_q;
                    end
                    if (hit_se_c) begin
                        sclk_d   = pol_q;
                        pcount_d = pcount_inc_c;
                        if (last_c) begin
                            stop_pend_d = 1'b0;
                            done_d      = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, all gated by the tick qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            div_q       <= MIN_DIV_W;
            ccount_q    <= '0;
            pol_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            sclk_q      <= 1'b0;
            done_q      <= 1'b0;
            pcount_q    <= '0;
            fc_q        <= 1'b0;
            fe_q        <= 1'b0;
            sc_q        <= 1'b0;
            se_q        <= 1'b0;
        end else if (clk_en) begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            ccount_q    <= ccount_d;
            pol_q       <= pol_d;
            stop_pend_q <= stop_pend_d;
            sclk_q      <= sclk_d;
            done_q      <= done_d;
            pcount_q    <= pcount_d;
            fc_q        <= fc_d;
            fe_q        <= fe_d;
            sc_q        <= sc_d;
            se_q        <= se_d;
        end
    end

    assign busy          = (state_q == ST_RUN);
    assign sclk          = sclk_q;
    assign done          = done_q;
    assign period_count  = pcount_q;
    assign first_center  = fc_q;
    assign first_edge    = fe_q;
    assign second_center = sc_q;
    assign second_edge   = se_q;

endmodule
